// File: rtl/mult_share_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one start/done multiplier,
// with operand latching, stale-done filtering and a watchdog for a multiplier that never answers.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_mcand,
    input  logic [NUM_REQ*WIDTH-1:0]   req_mplier,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]           resp_product,
    output logic                       resp_err,
    output logic                       busy,
    output logic                       mult_start,
    output logic [WIDTH-1:0]           mult_mcand,
    output logic [WIDTH-1:0]           mult_mplier,
    input  logic [WIDTH-1:0]           mult_product,
    input  logic                       mult_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state_reg;
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] owner_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] product_reg;
    logic             err_reg;
    logic             done_clr_reg;
    logic [TMR_W-1:0] timer_reg;

    logic [IDX_W-1:0] scan_idx [NUM_REQ];
    logic [WIDTH-1:0] mcand_slice [NUM_REQ];
    logic [WIDTH-1:0] mplier_slice [NUM_REQ];
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr_next;
    logic             timer_expired;
    logic             done_accept;

    // scan_idx[k] is the k-th candidate in priority order, starting at rr_ptr.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            logic [IDX_W:0] sum;
            assign sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
            assign scan_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                                ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                : sum[IDX_W-1:0];
            assign mcand_slice[gi]  = req_mcand[gi*WIDTH +: WIDTH];
            assign mplier_slice[gi] = req_mplier[gi*WIDTH +: WIDTH];
            assign req_ready[gi]  = !reset && (state_reg == S_IDLE) && grant_found
                                    && (grant_idx == IDX_W'(gi));
            assign resp_valid[gi] = (state_reg == S_RESP) && (owner_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[scan_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[k];
            end
        end
    end

    assign rr_ptr_next   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign timer_expired = (timer_reg == TMR_W'(TIMEOUT - 1));
    // A done level left over from the previous op is ignored until it has been seen low.
    assign done_accept   = done_clr_reg && mult_done;

    assign busy         = (state_reg != S_IDLE);
    assign mult_start   = (state_reg == S_ISSUE);
    assign mult_mcand   = mcand_reg;
    assign mult_mplier  = mplier_reg;
    assign resp_product = (state_reg == S_RESP) ? product_reg : '0;
    assign resp_err     = (state_reg == S_RESP) && err_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            product_reg  <= '0;
            err_reg      <= 1'b0;
            done_clr_reg <= 1'b0;
            timer_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_found) begin
                        owner_reg  <= grant_idx;
                        mcand_reg  <= mcand_slice[grant_idx];
                        mplier_reg <= mplier_slice[grant_idx];
                        rr_ptr_reg <= rr_ptr_next;
                        state_reg  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_reg    <= '0;
                    done_clr_reg <= 1'b0;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    timer_reg <= timer_reg + 1'b1;
                    if (!mult_done) begin
                        done_clr_reg <= 1'b1;
                    end
                    if (done_accept) begin
                        product_reg <= mult_product;
                        err_reg     <= 1'b0;
                        state_reg   <= S_RESP;
                    end else if (timer_expired) begin
                        product_reg <= '0;
                        err_reg     <= 1'b1;
                        state_reg   <= S_RESP;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: stub multiplier with configurable latency, stale done and hang,
// a transaction-level reference model, a vector table, hand sequences and a random phase.
module tb_mult_share_arbiter;
    localparam int NR = 4;
    localparam int W  = 16;
    localparam int TO = 64;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_mcand;
    logic [NR*W-1:0]   req_mplier;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [W-1:0]      resp_product;
    logic              resp_err;
    logic              busy;
    logic              mult_start;
    logic [W-1:0]      mult_mcand;
    logic [W-1:0]      mult_mplier;
    logic [W-1:0]      mult_product;
    logic              mult_done;

    always #5 clock = ~clock;

    mult_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_mcand(req_mcand), .req_mplier(req_mplier),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_product(resp_product),
        .resp_err(resp_err), .busy(busy), .mult_start(mult_start),
        .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
        .mult_product(mult_product), .mult_done(mult_done)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Requesters: a request drops by itself in the cycle after it was granted.
    bit         pend_valid [NR];
    logic [W-1:0] pend_a [NR];
    logic [W-1:0] pend_b [NR];
    int         pend_seq [NR];
    int         grant_seq [NR];
    int         grant_cyc_of [NR];

    for (genvar gi = 0; gi < NR; gi++) begin : g_req
        assign req_valid[gi] = pend_valid[gi] &&
                               !(grant_seq[gi] == pend_seq[gi] && cyc != grant_cyc_of[gi]);
        assign req_mcand[gi*W +: W]  = pend_a[gi];
        assign req_mplier[gi*W +: W] = pend_b[gi];
    end

    // Multiplier stub.
    int           lat_cfg = 4;
    int           stale_cfg = 0;
    bit           hang_cfg = 1'b0;
    int           cnt;
    int           stale_left;
    logic [W-1:0] res;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mult_done    <= 1'b0;
            mult_product <= '0;
            cnt          <= 0;
            stale_left   <= 0;
            res          <= '0;
        end else if (mult_start) begin
            cnt          <= lat_cfg;
            stale_left   <= stale_cfg;
            if (stale_cfg == 0) mult_done <= 1'b0;
            mult_product <= 16'hDEAD;
            res          <= mult_mcand * mult_mplier;
        end else if (cnt != 0) begin
            if (stale_left == 1) mult_done <= 1'b0;
            if (stale_left != 0) stale_left <= stale_left - 1;
            if (cnt == 1 && !hang_cfg) begin
                mult_done    <= 1'b1;
                mult_product <= res;
            end
            cnt <= cnt - 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: at most one operation in flight.
    int           model_rr;
    bit           outstanding;
    int           o_owner;
    logic [W-1:0] o_a, o_b, o_prod;
    bit           o_err;
    int           o_grant, o_due;
    int           resp_count = 0;
    int           start_total = 0;
    int           last_owner, last_grant_cyc, last_resp_cyc;
    logic [W-1:0] last_prod;
    bit           last_err;
    int           grant_log[$];

    task automatic monitor_loop();
        logic [NR-1:0] exp_ready, exp_rv;
        logic [31:0]   full;
        int            g, j;
        bit            exp_busy, exp_start;
        forever begin
            @(negedge clock);
            if (reset) begin
                model_rr    = 0;
                outstanding = 1'b0;
                check(req_ready == '0 && resp_valid == '0 && !mult_start && !busy &&
                      resp_product == '0 && !resp_err, "reset_quiet",
                      64'({req_ready, resp_valid, mult_start, busy, resp_err, resp_product}), 64'(0));
                continue;
            end
            g = -1;
            if (!outstanding) begin
                for (int k = 0; k < NR; k++) begin
                    j = (model_rr + k) % NR;
                    if (g < 0 && req_valid[IW'(j)]) g = j;
                end
            end
            exp_ready = (g >= 0) ? (NR'(1) << g) : '0;
            check(req_ready == exp_ready, "grant", 64'(req_ready), 64'(exp_ready));
            if (g >= 0) begin
                outstanding     = 1'b1;
                o_owner         = g;
                o_a             = pend_a[g];
                o_b             = pend_b[g];
                full            = 32'(o_a) * 32'(o_b);
                o_prod          = W'(full % 32'h10000);
                o_grant         = cyc;
                o_due           = -1;
                model_rr        = (g + 1) % NR;
                grant_seq[g]    = pend_seq[g];
                grant_cyc_of[g] = cyc;
                last_grant_cyc  = cyc;
                grant_log.push_back(g);
            end
            exp_busy = outstanding && cyc != o_grant;
            check(busy == exp_busy, "busy", 64'(busy), 64'(exp_busy));
            exp_start = outstanding && cyc == o_grant + 1;
            check(mult_start == exp_start, "mult_start", 64'(mult_start), 64'(exp_start));
            if (mult_start) start_total++;
            if (exp_start) begin
                o_err = hang_cfg;
                o_due = cyc + (hang_cfg ? TO + 1 : lat_cfg + 2);
            end
            if (outstanding && cyc > o_grant)
                check({mult_mcand, mult_mplier} == {o_a, o_b}, "operands",
                      64'({mult_mcand, mult_mplier}), 64'({o_a, o_b}));
            exp_rv = (outstanding && cyc == o_due) ? (NR'(1) << o_owner) : '0;
            check(resp_valid == exp_rv, "resp_valid", 64'(resp_valid), 64'(exp_rv));
            if (exp_rv != '0) begin
                check({resp_err, resp_product} == {o_err, o_err ? W'(0) : o_prod}, "resp_data",
                      64'({resp_err, resp_product}), 64'({o_err, o_err ? W'(0) : o_prod}));
                $display("resp #%0d owner=%0d a=%h b=%h product=%h err=%0b cycle=%0d",
                         resp_count, o_owner, o_a, o_b, resp_product, resp_err, cyc);
                last_owner    = o_owner;
                last_prod     = resp_product;
                last_err      = resp_err;
                last_resp_cyc = cyc;
                resp_count++;
                outstanding   = 1'b0;
            end else begin
                check(resp_product == '0 && !resp_err, "resp_idle_zero",
                      64'({resp_err, resp_product}), 64'(0));
            end
        end
    endtask

    task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        pend_a[r]     = a;
        pend_b[r]     = b;
        pend_seq[r]   = pend_seq[r] + 1;
        pend_valid[r] = 1'b1;
    endtask

    task automatic wait_resp();
        int  n0;
        bit  ok;
        n0 = resp_count;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(posedge clock);
            if (resp_count != n0) ok = 1'b1;
        end
        #1;
        check(ok, "resp_timeout", 64'(ok), 64'(1));
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(posedge clock);
            #1;
            if (req_valid == '0 && !busy && !outstanding) ok = 1'b1;
        end
        check(ok, "drain_timeout", 64'(ok), 64'(1));
    endtask

    typedef struct {
        int           owner;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic [W-1:0] prod;
    } vec_t;

    vec_t tbl[8];
    int   exp_order[8];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n0, s0;
        bit seen;
        tbl[0] = '{0, 16'h0002, 16'h0003, 16, 16'h0006};
        tbl[1] = '{1, 16'hFFFF, 16'h0003,  5, 16'hFFFD};
        tbl[2] = '{2, 16'hFFEC, 16'h0005,  5, 16'hFF9C};
        tbl[3] = '{3, 16'h0007, 16'h0009,  2, 16'h003F};
        tbl[4] = '{1, 16'h8000, 16'h0002,  1, 16'h0000};
        tbl[5] = '{2, 16'h1234, 16'h0010,  7, 16'h2340};
        tbl[6] = '{0, 16'hFFFF, 16'hFFFF,  3, 16'h0001};
        tbl[7] = '{3, 16'h0000, 16'hABCD,  9, 16'h0000};
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < NR; i++) begin
            pend_valid[i] = 1'b0; pend_a[i] = '0; pend_b[i] = '0;
            pend_seq[i] = 0; grant_seq[i] = -1; grant_cyc_of[i] = 0;
        end
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Vector table: one op each, fixed product and grant-to-response latency.
        for (int t = 0; t < 8; t++) begin
            lat_cfg = tbl[t].lat;
            s0 = start_total;
            issue(tbl[t].owner, tbl[t].a, tbl[t].b);
            wait_resp();
            check(last_owner == tbl[t].owner && last_prod == tbl[t].prod && !last_err, "table_result",
                  64'({last_err, last_prod}), 64'({1'b0, tbl[t].prod}));
            check(last_resp_cyc - last_grant_cyc == 3 + tbl[t].lat, "table_latency",
                  64'(last_resp_cyc - last_grant_cyc), 64'(3 + tbl[t].lat));
            check(start_total - s0 == 1, "one_start", 64'(start_total - s0), 64'(1));
        end

        // req1 then req2, then everyone asks: rr pointer must sit at 3.
        lat_cfg = 5;
        issue(1, 16'hFFFF, 16'h0003);
        wait_resp();
        check(last_prod == 16'hFFFD, "seq2_first", 64'(last_prod), 64'(16'hFFFD));
        issue(2, 16'hFFEC, 16'h0005);
        wait_resp();
        check(last_prod == 16'hFF9C, "seq2_second", 64'(last_prod), 64'(16'hFF9C));
        grant_log.delete();
        for (int i = 0; i < NR; i++) issue(i, 16'(i + 1), 16'h0011);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clock);
            if (grant_log.size() > 0) seen = 1'b1;
        end
        #1;
        check(seen && grant_log[0] == 3, "rr_after_seq2", 64'(seen ? grant_log[0] : -1), 64'(3));
        drain();

        // Four continuous requesters from a fresh reset: strict rotation.
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        grant_log.delete();
        lat_cfg = 3;
        for (int c = 0; c < 600 && grant_log.size() < 8; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < NR; i++)
                if (!req_valid[IW'(i)] && grant_log.size() < 8) issue(i, 16'(i + c), 16'h0003);
        end
        drain();
        check(grant_log.size() >= 8, "rotation_count", 64'(grant_log.size()), 64'(8));
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            check(grant_log[k] == exp_order[k], "rotation_order", 64'(grant_log[k]), 64'(exp_order[k]));

        // done still high from the previous op must not be taken as this op's result.
        lat_cfg = 8;
        stale_cfg = 3;
        issue(0, 16'h0005, 16'h0006);
        wait_resp();
        check(last_prod == 16'h001E && !last_err, "stale_done", 64'({last_err, last_prod}), 64'(16'h001E));
        check(last_resp_cyc - last_grant_cyc == 11, "stale_latency",
              64'(last_resp_cyc - last_grant_cyc), 64'(11));
        stale_cfg = 0;

        // Hung multiplier: watchdog response, then normal service resumes.
        hang_cfg = 1'b1;
        issue(2, 16'h0010, 16'h0010);
        wait_resp();
        check(last_err && last_prod == '0 && last_owner == 2, "timeout_resp",
              64'({last_err, last_prod}), 64'({1'b1, 16'h0000}));
        check(last_resp_cyc - last_grant_cyc == TO + 2, "timeout_latency",
              64'(last_resp_cyc - last_grant_cyc), 64'(TO + 2));
        hang_cfg = 1'b0;
        lat_cfg = 4;
        issue(0, 16'h0003, 16'h0004);
        wait_resp();
        check(last_prod == 16'h000C && !last_err, "after_timeout", 64'({last_err, last_prod}), 64'(16'h000C));

        // Reset while waiting on the multiplier.
        lat_cfg = 20;
        issue(1, 16'h1111, 16'h0002);
        repeat (6) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check(!mult_start && !busy && resp_valid == '0 && req_ready == '0 && resp_product == '0 &&
              mult_mcand == '0, "async_reset_outputs",
              64'({mult_start, busy, resp_valid, req_ready, resp_product}), 64'(0));
        n0 = resp_count;
        for (int i = 0; i < NR; i++) pend_valid[i] = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        check(resp_count == n0, "no_resp_after_reset", 64'(resp_count), 64'(n0));
        lat_cfg = 6;
        issue(3, 16'h0007, 16'h0009);
        wait_resp();
        check(last_prod == 16'h003F && last_owner == 3, "post_reset_op", 64'(last_prod), 64'(16'h003F));

        // Random traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            @(posedge clock);
            #1;
            if (!busy && $urandom_range(0, 3) == 0) begin
                lat_cfg   = $urandom_range(1, 20);
                hang_cfg  = ($urandom_range(0, 15) == 0);
                stale_cfg = (!hang_cfg && $urandom_range(0, 1) == 1) ? $urandom_range(0, lat_cfg - 1) : 0;
            end
            for (int i = 0; i < NR; i++)
                if (!req_valid[IW'(i)] && $urandom_range(0, 2) == 0)
                    issue(i, W'($urandom), W'($urandom));
        end
        drain();
        hang_cfg = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
